// File: rtl/mips_hazard_pkg.sv
// mips_hazard_pkg: shared register-address width, forwarding select codes and
// the source/destination match rule used by the read-hazard unit.
package mips_hazard_pkg;
   localparam int REG_AW = 5;
   typedef logic [REG_AW-1:0] reg_addr_t;
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;
   localparam reg_addr_t REG_ZERO = '0;
   // $0 is hardwired, so a write to it never creates a dependency
   function automatic logic reg_match(input logic use_src, input logic wr,
                                      input reg_addr_t src, input reg_addr_t dst);
      return use_src & wr & (src == dst) & (src != REG_ZERO);
   endfunction
endpackage

// File: rtl/reg_read_hazard_if.sv
// reg_read_hazard_if: decode/execute source and destination tags in, stall,
// bubble, forwarding selects and write-back address out.
interface reg_read_hazard_if;
   import mips_hazard_pkg::*;
   logic       stall_ext;
   logic       flushE;
   reg_addr_t  rsD;
   reg_addr_t  rtD;
   logic       useRsD;
   logic       useRtD;
   reg_addr_t  waE;
   logic       regWriteE;
   logic       memReadE;
   logic       stallD;
   logic       bubbleE;
   logic [1:0] fwdAE;
   logic [1:0] fwdBE;
   reg_addr_t  waW;
   logic       regWriteW;
   modport master(output stall_ext, flushE, rsD, rtD, useRsD, useRtD, waE, regWriteE, memReadE,
                  input stallD, bubbleE, fwdAE, fwdBE, waW, regWriteW);
   modport slave(input stall_ext, flushE, rsD, rtD, useRsD, useRtD, waE, regWriteE, memReadE,
                 output stallD, bubbleE, fwdAE, fwdBE, waW, regWriteW);
endinterface

// File: rtl/reg_read_hazard_tag_stage.sv
// hazard_tag_stage: holdable destination tag (addr, regWrite, memRead) for one
// pipeline stage.
module hazard_tag_stage
   import mips_hazard_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      hold,
   input  reg_addr_t addr_d,
   input  logic      wr_d,
   input  logic      rd_d,
   output reg_addr_t addr_q,
   output logic      wr_q,
   output logic      rd_q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= REG_ZERO;
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
      end else if (!hold) begin
         addr_q <= addr_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
      end
   end
endmodule

// File: rtl/reg_read_hazard.sv
// reg_read_hazard: tracks in-flight destinations through M/W and resolves
// read hazards; REG_FWD_EN selects forwarding + load-use stall, else pure interlock.
module reg_read_hazard
   import mips_hazard_pkg::*;
(
   input logic clk,
   input logic rst_n,
   reg_read_hazard_if.slave hz
);
   reg_addr_t  rs_e_q, rs_e_d, rt_e_q, rt_e_d;
   logic       use_rs_e_q, use_rs_e_d, use_rt_e_q, use_rt_e_d;
   reg_addr_t  wa_m, wa_w;
   logic       wr_m, rd_m, wr_w, rd_w;
   logic       stall;
   logic [1:0] fwd_a, fwd_b;

   hazard_tag_stage u_m (
      .clk(clk), .rst_n(rst_n), .hold(hz.stall_ext),
      .addr_d(hz.waE), .wr_d(hz.regWriteE), .rd_d(hz.memReadE),
      .addr_q(wa_m), .wr_q(wr_m), .rd_q(rd_m)
   );

   hazard_tag_stage u_w (
      .clk(clk), .rst_n(rst_n), .hold(hz.stall_ext),
      .addr_d(wa_m), .wr_d(wr_m), .rd_d(rd_m),
      .addr_q(wa_w), .wr_q(wr_w), .rd_q(rd_w)
   );

   always_comb begin
`ifdef REG_FWD_EN
      stall = rst_n & hz.memReadE & hz.regWriteE &
              (reg_match(hz.useRsD, 1'b1, hz.rsD, hz.waE) | reg_match(hz.useRtD, 1'b1, hz.rtD, hz.waE));
      fwd_a = reg_match(use_rs_e_q, wr_m, rs_e_q, wa_m) ? FWD_M :
              reg_match(use_rs_e_q, wr_w, rs_e_q, wa_w) ? FWD_W : FWD_RF;
      fwd_b = reg_match(use_rt_e_q, wr_m, rt_e_q, wa_m) ? FWD_M :
              reg_match(use_rt_e_q, wr_w, rt_e_q, wa_w) ? FWD_W : FWD_RF;
`else
      // no write-through register file, so a writer in W still blocks the read
      stall = rst_n & (reg_match(hz.useRsD, hz.regWriteE, hz.rsD, hz.waE) |
                       reg_match(hz.useRsD, wr_m, hz.rsD, wa_m) |
                       reg_match(hz.useRsD, wr_w, hz.rsD, wa_w) |
                       reg_match(hz.useRtD, hz.regWriteE, hz.rtD, hz.waE) |
                       reg_match(hz.useRtD, wr_m, hz.rtD, wa_m) |
                       reg_match(hz.useRtD, wr_w, hz.rtD, wa_w));
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
`endif
      rs_e_d     = hz.rsD;
      rt_e_d     = hz.rtD;
      use_rs_e_d = hz.useRsD & ~hz.flushE & ~stall;
      use_rt_e_d = hz.useRtD & ~hz.flushE & ~stall;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs_e_q     <= REG_ZERO;
         rt_e_q     <= REG_ZERO;
         use_rs_e_q <= 1'b0;
         use_rt_e_q <= 1'b0;
      end else if (!hz.stall_ext) begin
         rs_e_q     <= rs_e_d;
         rt_e_q     <= rt_e_d;
         use_rs_e_q <= use_rs_e_d;
         use_rt_e_q <= use_rt_e_d;
      end
   end

   assign hz.stallD    = stall;
   assign hz.bubbleE   = stall;
   assign hz.fwdAE     = fwd_a;
   assign hz.fwdBE     = fwd_b;
   assign hz.waW       = wa_w;
   assign hz.regWriteW = wr_w;
endmodule

// File: tb/tb_reg_read_hazard.sv
// tb_reg_read_hazard: per-scenario stimulus tables with a scoreboard of expected
// stall/forward/write-back values; expectations follow REG_FWD_EN.
module tb_reg_read_hazard;
   import mips_hazard_pkg::*;

   typedef struct packed {
      logic xs, fl;
      logic [4:0] rs, rt;
      logic urs, urt;
      logic [4:0] wa;
      logic rw, mr;
      logic st;
      logic [1:0] fa, fb;
      logic [4:0] waw;
      logic rww;
   } step_t;

   typedef struct packed {
      logic st;
      logic [1:0] fa, fb;
      logic [4:0] waw;
      logic rww;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   reg_read_hazard_if hif();
   reg_read_hazard dut(.clk(clk), .rst_n(rst_n), .hz(hif.slave));

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic step_t s(int xs, int fl, int rs, int rt, int urs, int urt, int wa, int rw,
                               int mr, int st, int fa, int fb, int waw, int rww);
      step_t r;
      r.xs = 1'(xs); r.fl = 1'(fl); r.rs = 5'(rs); r.rt = 5'(rt);
      r.urs = 1'(urs); r.urt = 1'(urt); r.wa = 5'(wa); r.rw = 1'(rw); r.mr = 1'(mr);
      r.st = 1'(st); r.fa = 2'(fa); r.fb = 2'(fb); r.waw = 5'(waw); r.rww = 1'(rww);
      return r;
   endfunction

   function automatic exp_t got();
      return '{hif.stallD, hif.fwdAE, hif.fwdBE, hif.waW, hif.regWriteW};
   endfunction

   task automatic apply(input step_t t);
      @(negedge clk);
      hif.stall_ext = t.xs; hif.flushE = t.fl;
      hif.rsD = t.rs; hif.rtD = t.rt; hif.useRsD = t.urs; hif.useRtD = t.urt;
      hif.waE = t.wa; hif.regWriteE = t.rw; hif.memReadE = t.mr;
      sb.push_back('{t.st, t.fa, t.fb, t.waw, t.rww});
   endtask

   task automatic do_reset();
      @(negedge clk);
      apply_idle();
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
   endtask

   task automatic apply_idle();
      hif.stall_ext = 1'b0; hif.flushE = 1'b0;
      hif.rsD = '0; hif.rtD = '0; hif.useRsD = 1'b0; hif.useRtD = 1'b0;
      hif.waE = '0; hif.regWriteE = 1'b0; hif.memReadE = 1'b0;
   endtask

   task automatic test_reset();
      step_t t[$];
      exp_t e;
      t = '{s(0,0,0,0,0,0,9,1,0, 0,0,0,0,0),
            s(0,0,0,0,0,0,0,0,0, 0,0,0,0,0),
            s(0,0,0,5,0,1,5,1,1, 1,0,0,9,1)};
      do_reset();
      foreach (t[i]) begin
         apply(t[i]);
         #2;
         e = sb.pop_front();
         checks++;
         if (got() !== e || hif.bubbleE !== e.st) begin
            errors++;
            $display("FAIL reset_pre step %0d: got %h bub=%b, exp %h", i, got(), hif.bubbleE, e);
         end
      end
      rst_n = 1'b0;
      sb.push_back('0);
      #1;
      e = sb.pop_front();
      checks++;
      if (got() !== e || hif.bubbleE !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got %h bub=%b, exp %h", got(), hif.bubbleE, e);
      end
      @(negedge clk);
      sb.push_back('0);
      e = sb.pop_front();
      checks++;
      if (got() !== e || hif.bubbleE !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: got %h bub=%b, exp %h", got(), hif.bubbleE, e);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_alu_chain();
      step_t t[$];
      exp_t e;
`ifdef REG_FWD_EN
      t = '{s(0,0,3,0,1,0,3,1,0, 0,0,0,0,0),
            s(1,0,0,0,0,0,0,0,0, 0,2,0,0,0),
            s(0,0,0,0,0,0,0,0,0, 0,2,0,0,0),
            s(0,0,0,0,0,0,0,0,0, 0,0,0,3,1)};
`else
      t = '{s(0,0,4,0,1,0,4,1,0, 1,0,0,0,0),
            s(0,0,4,0,1,0,0,0,0, 1,0,0,0,0),
            s(0,0,4,0,1,0,0,0,0, 1,0,0,4,1),
            s(0,0,4,0,1,0,0,0,0, 0,0,0,0,0),
            s(0,0,0,0,0,0,0,0,0, 0,0,0,0,0)};
`endif
      do_reset();
      foreach (t[i]) begin
         apply(t[i]);
         #2;
         e = sb.pop_front();
         checks++;
         if (got() !== e || hif.bubbleE !== e.st) begin
            errors++;
            $display("FAIL alu_chain step %0d: got %h bub=%b, exp %h", i, got(), hif.bubbleE, e);
         end
      end
   endtask

   task automatic test_load_use();
      step_t t[$];
      exp_t e;
`ifdef REG_FWD_EN
      t = '{s(0,0,0,5,0,1,5,1,1, 1,0,0,0,0),
            s(0,0,0,5,0,1,0,0,0, 0,0,0,0,0),
            s(0,0,0,0,0,0,0,0,0, 0,0,1,5,1),
            s(0,0,0,0,0,0,0,0,0, 0,0,0,0,0)};
`else
      t = '{s(0,0,0,5,0,1,5,1,1, 1,0,0,0,0),
            s(0,0,0,5,0,1,0,0,0, 1,0,0,0,0),
            s(0,0,0,5,0,1,0,0,0, 1,0,0,5,1),
            s(0,0,0,5,0,1,0,0,0, 0,0,0,0,0),
            s(0,0,0,0,0,0,0,0,0, 0,0,0,0,0)};
`endif
      do_reset();
      foreach (t[i]) begin
         apply(t[i]);
         #2;
         e = sb.pop_front();
         checks++;
         if (got() !== e || hif.bubbleE !== e.st) begin
            errors++;
            $display("FAIL load_use step %0d: got %h bub=%b, exp %h", i, got(), hif.bubbleE, e);
         end
      end
   endtask

   task automatic test_zero_priority();
      step_t t[$];
      exp_t e;
`ifdef REG_FWD_EN
      t = '{s(0,0,0,0,1,1,0,1,0, 0,0,0,0,0),
            s(0,0,7,7,1,1,7,1,0, 0,0,0,0,0),
            s(0,0,7,7,1,1,7,1,0, 0,2,2,0,1),
            s(0,0,0,0,0,0,0,0,0, 0,2,2,7,1),
            s(0,0,0,0,0,0,0,0,0, 0,0,0,7,1)};
`else
      t = '{s(0,0,0,0,1,1,0,1,0, 0,0,0,0,0),
            s(0,0,0,0,1,0,0,0,0, 0,0,0,0,0),
            s(0,0,0,0,1,0,0,0,0, 0,0,0,0,1),
            s(0,0,3,0,1,0,3,1,0, 1,0,0,0,0)};
`endif
      do_reset();
      foreach (t[i]) begin
         apply(t[i]);
         #2;
         e = sb.pop_front();
         checks++;
         if (got() !== e || hif.bubbleE !== e.st) begin
            errors++;
            $display("FAIL zero_priority step %0d: got %h bub=%b, exp %h", i, got(), hif.bubbleE, e);
         end
      end
   endtask

   task automatic test_stall_flush();
      step_t t[$];
      exp_t e;
`ifdef REG_FWD_EN
      t = '{s(0,0,0,0,0,0,2,1,0, 0,0,0,0,0),
            s(0,0,6,0,1,0,6,1,0, 0,0,0,0,0),
            s(1,1,9,0,1,0,9,1,0, 0,2,0,2,1),
            s(1,1,9,0,1,0,9,1,0, 0,2,0,2,1),
            s(0,1,6,0,1,0,0,0,0, 0,2,0,2,1),
            s(0,0,0,0,0,0,0,0,0, 0,0,0,6,1)};
`else
      t = '{s(0,0,0,0,0,0,2,1,0, 0,0,0,0,0),
            s(0,0,0,0,0,0,6,1,0, 0,0,0,0,0),
            s(1,1,9,0,1,0,9,1,0, 1,0,0,2,1),
            s(1,1,6,0,1,0,0,0,0, 1,0,0,2,1),
            s(0,1,0,0,0,0,0,0,0, 0,0,0,2,1),
            s(0,0,0,0,0,0,0,0,0, 0,0,0,6,1)};
`endif
      do_reset();
      foreach (t[i]) begin
         apply(t[i]);
         #2;
         e = sb.pop_front();
         checks++;
         if (got() !== e || hif.bubbleE !== e.st) begin
            errors++;
            $display("FAIL stall_flush step %0d: got %h bub=%b, exp %h", i, got(), hif.bubbleE, e);
         end
      end
   endtask

   initial begin
      apply_idle();
      test_reset();
      test_alu_chain();
      test_load_use();
      test_zero_priority();
      test_stall_flush();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_read_hazard.md
# reg_read_hazard

Read-side companion to the execute-stage write-address select in the 5-stage MIPS pipeline. Tracks every in-flight destination register (address from the write-address mux, plus write/load flags) through the M and W stages. Compares those destinations against decode-stage and execute-stage source registers. Produces operand forwarding selects, load-use stalls and bubble insertion, and delivers the final write-back address and enable to the register file.

## Interface
- No parameters; widths fixed by the ISA: 5-bit register address, 32 registers.
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- stall_ext  in  1  global freeze (memory stall); all internal state holds
- flushE  in  1  kill the instruction entering E (branch/jump redirect)
- rsD, rtD  in  5 each  decode-stage source addresses
- useRsD, useRtD  in  1 each  decode instruction actually reads rs/rt
- waE  in  5  execute-stage destination from the write-address mux (rd / rt / 31)
- regWriteE  in  1  E instruction writes the register file
- memReadE  in  1  E instruction is a load
- stallD  out  1  hold PC and the D pipeline register
- bubbleE  out  1  zero control in the D→E register this edge
- fwdAE, fwdBE  out  2 each  E operand select: 00 register file, 01 W result, 10 M result
- waW  out  5  write-back address to the register file
- regWriteW  out  1  write-back enable

## Operation
- Internal registered stages:
  - E: rsE, rtE, useRsE, useRtE, captured from the D inputs.
  - M: waM, regWriteM, memReadM, captured from the E inputs.
  - W: waW, regWriteW, captured from M.
- Match rule: a source matches a stage when its use bit is set, that stage's write enable is set, the addresses are equal, and the address is not 0. Register $0 never matches.
- fwdAE/fwdBE with REG_FWD_EN defined:
  - 10 if rsE/rtE matches M.
  - Otherwise 01 if it matches W.
  - Otherwise 00.
  - M has priority over W.
- Load-use stall with REG_FWD_EN defined: stallD = 1 when E holds a load (memReadE & regWriteE) whose waE matches rsD or rtD under the match rule.
- bubbleE equals stallD. On a bubble edge, useRsE/useRtE load 0, so the bubble never forwards.
- flushE: useRsE/useRtE load 0 at the next edge. The E-stage write flags are cleared upstream by the pipeline register; this block treats regWriteE as given.
- stall_ext = 1: every internal register holds. This wins over flushE and bubble. Combinational outputs keep evaluating on held state.
- waW/regWriteW are driven directly from the W registers.

## Timing
- All stage registers update on the rising edge of clk when stall_ext = 0.
- stallD, bubbleE, fwdAE, fwdBE are combinational from current inputs and state, valid in the same cycle.
- A load followed by a dependent instruction costs exactly 1 stall cycle, then the value comes from W (fwd 01).
- A back-to-back ALU dependency costs 0 stalls (fwd 10).
- Reset (asynchronous, any cycle, including mid-stall): all use/write/load flags go to 0 and all addresses go to 0. Outputs: stallD = 0, bubbleE = 0, fwdAE = fwdBE = 00, waW = 0, regWriteW = 0.
- Simultaneous M and W match on the same address: M wins (younger value).
- rs == rt, both matching: fwdAE and fwdBE carry identical selects.

## Configuration
- REG_FWD_EN defined: forwarding and the single-cycle load-use stall behave as above.
- REG_FWD_EN undefined: pure interlock.
  - fwdAE/fwdBE are tied to 00.
  - stallD = 1 while rsD/rtD match any in-flight writer in E (waE/regWriteE), M, or W. The register file is not write-through, so W counts.
  - Every stall also asserts bubbleE.

## Structure
- Shared package mips_hazard_pkg holds:
  - FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10
  - REG_ZERO = 5'd0
  - the register-address width constant
- One sub-module, hazard_tag_stage: a holdable destination-tag register (addr, regWrite, memRead) with asynchronous active-low reset. Instantiated for M and W.
- Compare/priority logic stays in the top level.

## Test plan
- Reset: assert rst_n = 0 mid-stream with a load in E. Outputs immediately become stallD = 0, fwd 00, regWriteW = 0, waW = 0.
- ALU chain: add $3 (waE = 3, regWriteE = 1), next instruction uses rs = 3. Next cycle fwdAE = 10; one cycle later, if still in E under stall_ext, it stays 10.
- Load-use: lw $5 in E, D has rtD = 5 with useRtD = 1. stallD = bubbleE = 1 for exactly one cycle, then fwdBE = 01.
- $0 and priority:
  - waE = 0 with regWriteE = 1 never forwards.
  - M and W both writing $7 with rsE = 7 gives fwdAE = 10.
- stall_ext/flush: stall_ext = 1 with flushE = 1 holds all state, and waW is unchanged. After release, flushE clears useRsE, so fwdAE = 00.
- REG_FWD_EN undefined: add $4 then use $4. stallD stays 1 for 3 cycles (E, M, W), then drops; fwd remains 00 throughout.
